// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: streams weights and biases from an external memory,
// accumulates signed fixed-point dot products, then scales, saturates and optionally applies ReLU.
module nn_layer_engine #(
    parameter int DATA_LEN     = 16,
    parameter int FRAC_BITS    = 8,
    parameter int IN_COUNT     = 4,
    parameter int NEURON_COUNT = 4,
    parameter int ADDR_LEN     = 16,
    localparam int XIDX_W      = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
    localparam int YIDX_W      = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       start_i,
    input  logic                       relu_i,
    input  logic [ADDR_LEN-1:0]        base_addr_i,
    input  logic                       x_we_i,
    input  logic [XIDX_W-1:0]          x_idx_i,
    input  logic signed [DATA_LEN-1:0] x_data_i,
    output logic                       mem_rd_o,
    output logic [ADDR_LEN-1:0]        mem_addr_o,
    input  logic signed [DATA_LEN-1:0] mem_data_i,
    output logic                       y_valid_o,
    output logic [YIDX_W-1:0]          y_idx_o,
    output logic signed [DATA_LEN-1:0] y_data_o,
    output logic                       y_sat_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int K_W    = $clog2(IN_COUNT + 1);
    localparam int ACC_W  = 2 * DATA_LEN + K_W;
    localparam int STRIDE = IN_COUNT + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, READ, ACC, OUT, DONE} state_t;

    // Returns {saturated, value}: floor-shift out the fraction, clamp, then optional ReLU.
    function automatic logic [DATA_LEN:0] scale_sat(input logic signed [ACC_W-1:0] acc,
                                                    input logic relu);
        logic signed [ACC_W-1:0] shifted;
        logic [DATA_LEN-1:0]     val;
        logic                    sat;
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            val = SAT_MAX[DATA_LEN-1:0];
            sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            val = SAT_MIN[DATA_LEN-1:0];
            sat = 1'b1;
        end else begin
            val = shifted[DATA_LEN-1:0];
            sat = 1'b0;
        end
        if (relu && val[DATA_LEN-1]) begin
            val = '0;
        end else begin
            val = val;
        end
        return {sat, val};
    endfunction

    state_t                      state_r, state_nxt_s;
    logic [YIDX_W-1:0]           n_r, n_nxt_s;
    logic [K_W-1:0]              k_r, k_nxt_s;
    logic signed [ACC_W-1:0]     acc_r, acc_nxt_s;
    logic                        relu_r, relu_nxt_s;
    logic [ADDR_LEN-1:0]         base_r, base_nxt_s;
    logic signed [DATA_LEN-1:0]  x_r [IN_COUNT];

    logic signed [2*DATA_LEN-1:0] prod_s;
    logic signed [ACC_W-1:0]      prod_ext_s;
    logic signed [ACC_W-1:0]      bias_ext_s;
    logic [ADDR_LEN-1:0]          addr_s;
    logic [DATA_LEN:0]            sat_s;

    logic                        mem_rd_r, y_valid_r, y_sat_r, busy_r, done_r;
    logic [ADDR_LEN-1:0]         mem_addr_r;
    logic [YIDX_W-1:0]           y_idx_r;
    logic signed [DATA_LEN-1:0]  y_data_r;

    // Datapath terms: weight product, bias aligned to the product's binary point, read address.
    always_comb begin
        prod_s     = mem_data_i * x_r[k_r[XIDX_W-1:0]];
        prod_ext_s = {{(ACC_W-2*DATA_LEN){prod_s[2*DATA_LEN-1]}}, prod_s};
        bias_ext_s = {{(ACC_W-DATA_LEN-FRAC_BITS){mem_data_i[DATA_LEN-1]}}, mem_data_i,
                      {FRAC_BITS{1'b0}}};
        addr_s     = base_nxt_s + ADDR_LEN'(n_nxt_s) * ADDR_LEN'(STRIDE) + ADDR_LEN'(k_nxt_s);
        sat_s      = scale_sat(acc_nxt_s, relu_r);
    end

    // Next-state and control-register update for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        n_nxt_s     = n_r;
        k_nxt_s     = k_r;
        acc_nxt_s   = acc_r;
        relu_nxt_s  = relu_r;
        base_nxt_s  = base_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    relu_nxt_s  = relu_i;
                    base_nxt_s  = base_addr_i;
                    n_nxt_s     = '0;
                    k_nxt_s     = '0;
                    acc_nxt_s   = '0;
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: state_nxt_s = ACC;
            ACC: begin
                if (k_r == K_W'(IN_COUNT)) begin
                    acc_nxt_s   = acc_r + bias_ext_s;
                    state_nxt_s = OUT;
                end else begin
                    acc_nxt_s   = acc_r + prod_ext_s;
                    k_nxt_s     = k_r + K_W'(1);
                    state_nxt_s = READ;
                end
            end
            OUT: begin
                acc_nxt_s = '0;
                k_nxt_s   = '0;
                if (n_r == YIDX_W'(NEURON_COUNT - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    n_nxt_s     = n_r + YIDX_W'(1);
                    state_nxt_s = READ;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state plus outputs registered from the upcoming state so they align with it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r    <= IDLE;
            n_r        <= '0;
            k_r        <= '0;
            acc_r      <= '0;
            relu_r     <= 1'b0;
            base_r     <= '0;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            y_valid_r  <= 1'b0;
            y_idx_r    <= '0;
            y_data_r   <= '0;
            y_sat_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            n_r        <= n_nxt_s;
            k_r        <= k_nxt_s;
            acc_r      <= acc_nxt_s;
            relu_r     <= relu_nxt_s;
            base_r     <= base_nxt_s;
            mem_rd_r   <= (state_nxt_s == READ);
            mem_addr_r <= (state_nxt_s == READ) ? addr_s : '0;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (state_nxt_s == DONE);
            y_valid_r  <= (state_nxt_s == OUT);
            if (state_nxt_s == OUT) begin
                y_idx_r  <= n_r;
                y_data_r <= sat_s[DATA_LEN-1:0];
                y_sat_r  <= sat_s[DATA_LEN];
            end
        end
    end

    // Input-vector register file; frozen while a run is in progress.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < IN_COUNT; i++) begin
                x_r[i] <= '0;
            end
        end else if (x_we_i && !busy_r) begin
            for (int i = 0; i < IN_COUNT; i++) begin
                if (x_idx_i == XIDX_W'(i)) begin
                    x_r[i] <= x_data_i;
                end
            end
        end
    end

    assign mem_rd_o   = mem_rd_r;
    assign mem_addr_o = mem_addr_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign y_valid_o  = y_valid_r;
    assign y_idx_o    = y_idx_r;
    assign y_data_o   = y_data_r;
    assign y_sat_o    = y_sat_r;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed bench for nn_layer_engine: two-neuron, four-input layer against a behavioural weight memory.
module tb_nn_layer_engine;

    logic               clk_i = 1'b0;
    logic               reset_ni;
    logic               start_i;
    logic               relu_i;
    logic [15:0]        base_addr_i;
    logic               x_we_i;
    logic [1:0]         x_idx_i;
    logic signed [15:0] x_data_i;
    logic               mem_rd_o;
    logic [15:0]        mem_addr_o;
    logic signed [15:0] mem_data_i;
    logic               y_valid_o;
    logic [0:0]         y_idx_o;
    logic signed [15:0] y_data_o;
    logic               y_sat_o;
    logic               busy_o;
    logic               done_o;

    logic signed [15:0] mem [0:15];

    int tests_run    = 0;
    int tests_failed = 0;
    int y_got [2];
    int s_got [2];
    int y_cnt, done_cnt, done_lat, a_cnt, addr_ok;

    always #5 clk_i = ~clk_i;

    nn_layer_engine #(
        .DATA_LEN(16), .FRAC_BITS(8), .IN_COUNT(4), .NEURON_COUNT(2), .ADDR_LEN(16)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .relu_i(relu_i),
        .base_addr_i(base_addr_i), .x_we_i(x_we_i), .x_idx_i(x_idx_i), .x_data_i(x_data_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .y_valid_o(y_valid_o), .y_idx_o(y_idx_o), .y_data_o(y_data_o), .y_sat_o(y_sat_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // Weight memory: data returned one cycle after the read request.
    always @(posedge clk_i) begin
        if (mem_rd_o) mem_data_i <= mem[mem_addr_o[3:0]];
    end

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic signed [15:0] w0, input logic signed [15:0] b0,
                           input logic signed [15:0] w1, input logic signed [15:0] b1);
        for (int i = 0; i < 16; i++) mem[i] = 16'sd0;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = w0;
            mem[5 + i] = w1;
        end
        mem[4] = b0;
        mem[9] = b1;
    endtask

    task automatic set_x(input logic signed [15:0] v0, input logic signed [15:0] v1,
                         input logic signed [15:0] v2, input logic signed [15:0] v3);
        logic signed [15:0] v [4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            x_we_i   = 1'b1;
            x_idx_i  = 2'(i);
            x_data_i = v[i];
        end
        @(negedge clk_i);
        x_we_i = 1'b0;
    endtask

    // mode 0: plain run; 1: stray start/x writes mid-run and in DONE; 2: reset during neuron 1 ACC.
    task automatic run(input logic relu, input int mode);
        y_got    = '{-99999, -99999};
        s_got    = '{-1, -1};
        y_cnt    = 0;
        done_cnt = 0;
        done_lat = 0;
        a_cnt    = 0;
        addr_ok  = 1;
        @(negedge clk_i);
        relu_i      = relu;
        base_addr_i = 16'h0100;
        start_i     = 1'b1;
        @(posedge clk_i);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            x_we_i  = 1'b0;
            if (mem_rd_o) begin
                if (mem_addr_o != 16'(256 + a_cnt)) addr_ok = 0;
                a_cnt++;
            end
            if (y_valid_o) begin
                y_got[y_idx_o] = int'(y_data_o);
                s_got[y_idx_o] = int'(y_sat_o);
                y_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_lat == 0) done_lat = c + 1;
            end
            if (mode == 1 && c == 4) begin
                start_i  = 1'b1;
                x_we_i   = 1'b1;
                x_idx_i  = 2'd0;
                x_data_i = 16'sh7fff;
            end
            if (mode == 1 && done_o) start_i = 1'b1;
            if (mode == 2 && c == 16) begin
                reset_ni = 1'b0;
                #1;
                check_val("rst_busy", busy_o, 1'b0);
                check_val("rst_memrd", mem_rd_o, 1'b0);
                check_val("rst_addr", mem_addr_o, 16'h0000);
                check_val("rst_yvalid", y_valid_o, 1'b0);
                check_val("rst_ydata", y_data_o, 16'sd0);
                check_val("rst_done", done_o, 1'b0);
            end
        end
    endtask

    task automatic check_res(input string tag, input int y0, input int y1,
                             input int s0, input int s1);
        check_val({tag, "_y0"}, y_got[0], y0);
        check_val({tag, "_y1"}, y_got[1], y1);
        check_val({tag, "_sat0"}, s_got[0], s0);
        check_val({tag, "_sat1"}, s_got[1], s1);
        check_val({tag, "_ycnt"}, y_cnt, 2);
        check_val({tag, "_donecnt"}, done_cnt, 1);
        check_val({tag, "_latency"}, done_lat, 23);
        check_val({tag, "_rdcnt"}, a_cnt, 10);
        check_val({tag, "_addrseq"}, addr_ok, 1);
        check_val({tag, "_busy_end"}, busy_o, 1'b0);
    endtask

    initial begin
        reset_ni    = 1'b0;
        start_i     = 1'b0;
        relu_i      = 1'b0;
        base_addr_i = 16'h0000;
        x_we_i      = 1'b0;
        x_idx_i     = 2'd0;
        x_data_i    = 16'sd0;
        mem_data_i  = 16'sd0;
        repeat (3) @(negedge clk_i);
        check_val("reset_busy", busy_o, 1'b0);
        check_val("reset_done", done_o, 1'b0);
        check_val("reset_memrd", mem_rd_o, 1'b0);
        check_val("reset_yvalid", y_valid_o, 1'b0);
        check_val("reset_ydata", y_data_o, 16'sd0);
        reset_ni = 1'b1;

        // 0.5*1.0*4 + 0.25 = 2.25 -> 576; -1.0*1.0*4 -> -1024
        set_mem(16'sd128, 16'sd64, -16'sd256, 16'sd0);
        set_x(16'sd256, 16'sd256, 16'sd256, 16'sd256);
        run(1'b0, 0);
        check_res("basic", 576, -1024, 0, 0);

        run(1'b1, 0);
        check_res("relu", 576, 0, 0, 0);

        set_mem(16'sd32767, 16'sd32767, -16'sd32768, 16'sd0);
        set_x(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
        run(1'b0, 0);
        check_res("sat", 32767, -32768, 1, 1);

        // -1 raw floors to -1; 32767*256 lands exactly on the upper bound without clamping
        set_mem(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        mem[1] = -16'sd1;
        mem[5] = 16'sd32767;
        set_x(16'sd256, 16'sd1, 16'sd0, 16'sd0);
        run(1'b0, 0);
        check_res("edge", -1, 32767, 0, 0);

        set_mem(16'sd128, 16'sd64, -16'sd256, 16'sd0);
        set_x(16'sd256, 16'sd256, 16'sd256, 16'sd256);
        run(1'b0, 1);
        check_res("stray", 576, -1024, 0, 0);

        run(1'b0, 2);
        check_val("abort_donecnt", done_cnt, 0);
        check_val("abort_ycnt", y_cnt, 1);
        @(negedge clk_i);
        reset_ni = 1'b1;

        // x cleared by reset: only the bias of neuron 0 survives
        run(1'b0, 0);
        check_res("xclr", 64, 0, 0, 0);

        set_x(16'sd256, 16'sd256, 16'sd256, 16'sd256);
        run(1'b0, 0);
        check_res("rerun", 576, -1024, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
